// File: rtl/if_id_stall_unit.sv
// PC register and IF/ID pipeline register with load-use stall, branch redirect/flush,
// and saturating stall/flush counters for performance debug.
module if_id_stall_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Hazard,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      IMemInst,
    output logic [31:0]      PC,
    output logic [31:0]      IF_IDInst,
    output logic [31:0]      IF_IDPC4,
    output logic             IF_IDValid,
    output logic             ID_EXBubble,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]      pc_plus4;

    // 32-bit modulo add: 0xFFFFFFFC wraps to 0
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (Hazard) begin
            // Branch operands are not ready during a load-use stall; branch is re-evaluated next cycle
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else if (BranchTaken) begin
            pc_d    = {BranchTarget[31:2], 2'b00};
            inst_d  = NOP_INST;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else begin
            pc_d    = pc_plus4;
            inst_d  = IMemInst;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC          = pc_q;
    assign IF_IDInst   = inst_q;
    assign IF_IDPC4    = pc4_q;
    assign IF_IDValid  = valid_q;
    assign ID_EXBubble = Hazard;
    assign StallCount  = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stall_unit.sv
// Directed testbench for if_id_stall_unit: fetch, stall, flush, priority, alignment,
// PC wrap, counter saturation and asynchronous reset.
module tb_if_id_stall_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        Hazard;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] IMemInst;
    logic [31:0] PC;
    logic [31:0] IF_IDInst;
    logic [31:0] IF_IDPC4;
    logic        IF_IDValid;
    logic        ID_EXBubble;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_stall_unit #(
        .RESET_PC(32'h00000000),
        .NOP_INST(32'h00000000),
        .CNT_W   (16)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Hazard      (Hazard),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .IMemInst    (IMemInst),
        .PC          (PC),
        .IF_IDInst   (IF_IDInst),
        .IF_IDPC4    (IF_IDPC4),
        .IF_IDValid  (IF_IDValid),
        .ID_EXBubble (ID_EXBubble),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    always #5 CLK = ~CLK;

    // Combinational instruction memory model
    always_comb begin
        case (PC)
            32'h00000000: IMemInst = 32'h00000011;
            32'h00000004: IMemInst = 32'h00000022;
            32'h00000008: IMemInst = 32'h00000033;
            32'h0000000C: IMemInst = 32'h00000044;
            32'h00000040: IMemInst = 32'h000000AA;
            default:      IMemInst = PC ^ 32'h5A5A0000;
        endcase
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        // thin wrapper kept only for formatting; comparisons are still done inline below
    endtask

    task automatic test_reset();
        RST_N = 1'b0; Hazard = 1'b1; BranchTaken = 1'b0; BranchTarget = 32'h0;
        #2;
        n_checks++; if (ID_EXBubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble_hi got %b exp 1", ID_EXBubble); end
        Hazard = 1'b0;
        tick(); tick();
        n_checks++; if (ID_EXBubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble_lo got %b exp 0", ID_EXBubble); end
        n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 00000000", PC); end
        n_checks++; if (IF_IDInst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h exp 00000000", IF_IDInst); end
        n_checks++; if (IF_IDPC4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h exp 00000000", IF_IDPC4); end
        n_checks++; if (IF_IDValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", IF_IDValid); end
        n_checks++; if (StallCount !== 16'h0 || FlushCount !== 16'h0) begin n_fail++; $display("FAIL reset_counts got %h/%h exp 0000/0000", StallCount, FlushCount); end
        RST_N = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_fetch_and_stall();
        tick();
        n_checks++; if (PC !== 32'h4 || IF_IDInst !== 32'h11 || IF_IDPC4 !== 32'h4 || IF_IDValid !== 1'b1) begin n_fail++; $display("FAIL fetch1 got pc=%h inst=%h pc4=%h v=%b exp 4/11/4/1", PC, IF_IDInst, IF_IDPC4, IF_IDValid); end
        tick();
        n_checks++; if (PC !== 32'h8 || IF_IDInst !== 32'h22 || IF_IDPC4 !== 32'h8) begin n_fail++; $display("FAIL fetch2 got pc=%h inst=%h pc4=%h exp 8/22/8", PC, IF_IDInst, IF_IDPC4); end
        Hazard = 1'b1;
        #1;
        n_checks++; if (ID_EXBubble !== 1'b1) begin n_fail++; $display("FAIL stall_bubble got %b exp 1", ID_EXBubble); end
        tick();
        n_checks++; if (PC !== 32'h8 || IF_IDInst !== 32'h22 || IF_IDPC4 !== 32'h8 || IF_IDValid !== 1'b1) begin n_fail++; $display("FAIL stall_hold got pc=%h inst=%h pc4=%h v=%b exp 8/22/8/1", PC, IF_IDInst, IF_IDPC4, IF_IDValid); end
        n_checks++; if (StallCount !== 16'd1) begin n_fail++; $display("FAIL stall_count got %0d exp 1", StallCount); end
        Hazard = 1'b0;
        tick();
        n_checks++; if (PC !== 32'hC || IF_IDInst !== 32'h33 || IF_IDPC4 !== 32'hC) begin n_fail++; $display("FAIL stall_resume got pc=%h inst=%h pc4=%h exp C/33/C", PC, IF_IDInst, IF_IDPC4); end
        n_checks++; if (ID_EXBubble !== 1'b0) begin n_fail++; $display("FAIL resume_bubble got %b exp 0", ID_EXBubble); end
        $display("test_fetch_and_stall done");
    endtask

    task automatic test_branch();
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        tick();
        n_checks++; if (PC !== 32'h40 || IF_IDInst !== 32'h0 || IF_IDPC4 !== 32'h0 || IF_IDValid !== 1'b0) begin n_fail++; $display("FAIL flush got pc=%h inst=%h pc4=%h v=%b exp 40/0/0/0", PC, IF_IDInst, IF_IDPC4, IF_IDValid); end
        n_checks++; if (FlushCount !== 16'd1) begin n_fail++; $display("FAIL flush_count got %0d exp 1", FlushCount); end
        BranchTaken = 1'b0;
        tick();
        n_checks++; if (PC !== 32'h44 || IF_IDInst !== 32'hAA || IF_IDPC4 !== 32'h44 || IF_IDValid !== 1'b1) begin n_fail++; $display("FAIL post_flush got pc=%h inst=%h pc4=%h v=%b exp 44/AA/44/1", PC, IF_IDInst, IF_IDPC4, IF_IDValid); end
        $display("test_branch done");
    endtask

    task automatic test_hazard_priority();
        Hazard = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
        tick();
        n_checks++; if (PC !== 32'h44 || IF_IDInst !== 32'hAA || IF_IDValid !== 1'b1) begin n_fail++; $display("FAIL prio_hold got pc=%h inst=%h v=%b exp 44/AA/1", PC, IF_IDInst, IF_IDValid); end
        n_checks++; if (StallCount !== 16'd2 || FlushCount !== 16'd1) begin n_fail++; $display("FAIL prio_counts got %0d/%0d exp 2/1", StallCount, FlushCount); end
        Hazard = 1'b0;
        tick();
        n_checks++; if (PC !== 32'h80 || IF_IDValid !== 1'b0 || FlushCount !== 16'd2) begin n_fail++; $display("FAIL prio_redirect got pc=%h v=%b fc=%0d exp 80/0/2", PC, IF_IDValid, FlushCount); end
        BranchTaken = 1'b0;
        $display("test_hazard_priority done");
    endtask

    task automatic test_align_and_wrap();
        BranchTaken = 1'b1; BranchTarget = 32'h43;
        tick();
        n_checks++; if (PC !== 32'h40 || FlushCount !== 16'd3) begin n_fail++; $display("FAIL misalign got pc=%h fc=%0d exp 40/3", PC, FlushCount); end
        // Stall honoured even while IF/ID holds a bubble
        BranchTaken = 1'b0; Hazard = 1'b1;
        tick();
        n_checks++; if (PC !== 32'h40 || IF_IDValid !== 1'b0 || StallCount !== 16'd3) begin n_fail++; $display("FAIL nop_stall got pc=%h v=%b sc=%0d exp 40/0/3", PC, IF_IDValid, StallCount); end
        Hazard = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'hFFFFFFFC;
        tick();
        n_checks++; if (PC !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_setup got pc=%h exp FFFFFFFC", PC); end
        BranchTaken = 1'b0;
        tick();
        n_checks++; if (PC !== 32'h0 || IF_IDPC4 !== 32'h0 || IF_IDInst !== 32'hA5A5FFFC || IF_IDValid !== 1'b1) begin n_fail++; $display("FAIL wrap got pc=%h pc4=%h inst=%h v=%b exp 0/0/A5A5FFFC/1", PC, IF_IDPC4, IF_IDInst, IF_IDValid); end
        $display("test_align_and_wrap done");
    endtask

    task automatic test_saturate_and_async_reset();
        Hazard = 1'b1;
        for (int i = 0; i < 65530; i++) @(posedge CLK);
        #1;
        n_checks++; if (StallCount !== 16'hFFFD || PC !== 32'h0) begin n_fail++; $display("FAIL sat_mid got sc=%h pc=%h exp FFFD/0", StallCount, PC); end
        for (int i = 0; i < 10; i++) @(posedge CLK);
        #1;
        n_checks++; if (StallCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stick got %h exp FFFF", StallCount); end
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++; if (PC !== 32'h0 || IF_IDValid !== 1'b0 || IF_IDInst !== 32'h0 || StallCount !== 16'h0 || FlushCount !== 16'h0) begin n_fail++; $display("FAIL async_reset got pc=%h v=%b inst=%h sc=%h fc=%h exp 0/0/0/0/0", PC, IF_IDValid, IF_IDInst, StallCount, FlushCount); end
        n_checks++; if (ID_EXBubble !== 1'b1) begin n_fail++; $display("FAIL async_reset_bubble got %b exp 1", ID_EXBubble); end
        Hazard = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        n_checks++; if (PC !== 32'h4 || IF_IDInst !== 32'h11 || IF_IDValid !== 1'b1) begin n_fail++; $display("FAIL post_reset_fetch got pc=%h inst=%h v=%b exp 4/11/1", PC, IF_IDInst, IF_IDValid); end
        $display("test_saturate_and_async_reset done");
    endtask

    initial begin
        test_reset();
        test_fetch_and_stall();
        test_branch();
        test_hazard_priority();
        test_align_and_wrap();
        test_saturate_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_stall_unit.md
Name: if_id_stall_unit

Overview:
- Consumer side of the load-use hazard interface: acts on the Hazard signal from the hazard detection logic.
- Owns the PC register and the IF/ID pipeline register.
- On Hazard it freezes PC and IF/ID and requests a bubble into ID/EX; on a taken branch resolved in ID it redirects PC and flushes IF/ID to a NOP.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INST, 32'h00000000, instruction word inserted into IF/ID on flush (MIPS sll $0,$0,0)
CNT_W, 16, width of StallCount and FlushCount

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
Hazard  input  1  load-use stall request, sampled every cycle
BranchTaken  input  1  branch resolved taken in ID this cycle
BranchTarget  input  32  branch destination address
IMemInst  input  32  instruction memory read data for current PC (combinational fetch)
PC  output  32  current fetch address, registered
IF_IDInst  output  32  instruction held in IF/ID, registered
IF_IDPC4  output  32  PC+4 of instruction in IF/ID, registered
IF_IDValid  output  1  1 = IF/ID holds a fetched instruction, 0 = bubble/NOP
ID_EXBubble  output  1  combinational, = Hazard; ID/EX loads zero control when 1
StallCount  output  CNT_W  number of stall cycles, saturating
FlushCount  output  CNT_W  number of flushes, saturating

Behaviour:
- Reset (RST_N=0, asynchronous, overrides everything):
  - PC=RESET_PC, IF_IDInst=NOP_INST, IF_IDPC4=0, IF_IDValid=0, StallCount=0, FlushCount=0.
  - ID_EXBubble follows Hazard even during reset.
- Per rising edge, priority Hazard > BranchTaken > normal:
  - Hazard=1:
    - PC, IF_IDInst, IF_IDPC4 and IF_IDValid hold.
    - StallCount+1 unless all-ones.
    - BranchTaken is ignored this cycle (branch operands are not yet valid); the branch is re-evaluated next cycle.
  - Hazard=0, BranchTaken=1:
    - PC <= {BranchTarget[31:2],2'b00}.
    - IF_IDInst <= NOP_INST, IF_IDPC4 <= 0, IF_IDValid <= 0.
    - FlushCount+1 unless all-ones.
  - Hazard=0, BranchTaken=0:
    - PC <= PC+4.
    - IF_IDInst <= IMemInst, IF_IDPC4 <= PC+4, IF_IDValid <= 1.
- Latency:
  - Instruction fetched at PC in cycle n appears on IF_IDInst after edge n+1.
  - Redirect takes effect on the edge following BranchTaken; exactly one instruction is squashed.
- ID_EXBubble = Hazard, purely combinational, same cycle; no register on this path.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Hazard held for k consecutive cycles: state frozen k edges, StallCount +k, ID_EXBubble=1 for all k cycles. No internal limit.
- Hazard asserted while IF_IDValid=0 (false match on NOP fields): stall is honoured anyway; the block never filters Hazard.
- Misaligned BranchTarget: low two bits forced to 0; no exception raised.
- Reset asserted mid-stall or mid-flush: immediate return to reset values; first fetch after release is from RESET_PC.

Test Plan:
- Release reset, IMemInst = 0x11,0x22,0x33 on PC 0,4,8 -> PC 0→4→8→C; IF_IDInst 0x11,0x22,0x33 one edge later; IF_IDPC4 4,8,C; IF_IDValid 1 after first edge.
- Hazard=1 for one cycle at PC=8 -> ID_EXBubble=1 that cycle; PC stays 8, IF_IDInst stays 0x22 over that edge; StallCount=1; fetch resumes to C next edge.
- BranchTaken=1, BranchTarget=0x40 at PC=C -> next edge PC=0x40, IF_IDInst=0, IF_IDValid=0, FlushCount=1; following edge IF_IDInst=IMemInst@0x40.
- Hazard=1 and BranchTaken=1 together, then BranchTaken alone -> first edge holds all state (StallCount+1, FlushCount unchanged); second edge redirects.
- BranchTarget=0x43 -> PC=0x40. Force PC=0xFFFFFFFC via branch then normal edge -> PC=0. StallCount preset near max with Hazard held -> sticks at 0xFFFF.
- Assert RST_N=0 between edges during a Hazard stall -> PC=RESET_PC, IF_IDValid=0, counters 0 immediately, without waiting for a clock edge.
